// File: rtl/bp_pkg.sv
// Shared definitions for the branch direction predictor: indexing mode
// constants, the default counter reset value and the saturating step helper
// used by both the per-entry counters and the statistics counters.
package bp_pkg;

  // Indexing modes selectable through the MODE parameter
  localparam int BP_MODE_BIMODAL = 0;
  localparam int BP_MODE_GSHARE  = 1;

  // Weakly not-taken for a 2-bit counter
  localparam int BP_CNT_INIT_DEFAULT = 1;

  // Widest counter the helper below can handle
  localparam int BP_SAT_MAX_W = 64;

  // One saturating step of a width-bit unsigned counter carried in a 64-bit
  // container. Counting up sticks at all-ones of the given width, counting
  // down sticks at zero. Callers truncate the result back to their width.
  function automatic logic [BP_SAT_MAX_W-1:0] sat_step(
    input logic [BP_SAT_MAX_W-1:0] val,
    input logic                    up,
    input int                      width
  );
    logic [BP_SAT_MAX_W-1:0] max_val;
    if (width >= BP_SAT_MAX_W) begin
      max_val = '1;
    end else begin
      max_val = (64'd1 << width) - 64'd1;
    end
    if (up) begin
      sat_step = (val >= max_val) ? max_val : val + 64'd1;
    end else begin
      sat_step = (val == '0) ? '0 : val - 64'd1;
    end
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Single saturating up/down counter used as one entry of the prediction
// table. Held in flops so the asynchronous reset reaches every entry.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W    = 2,
  parameter int CNT_INIT = BP_CNT_INIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(CNT_INIT);

  // Counter state: reset/clear to the initial value, otherwise step on enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= INIT_VAL;
    end else if (clear) begin
      cnt <= INIT_VAL;
    end else if (en) begin
      cnt <= CNT_W'(sat_step(BP_SAT_MAX_W'(cnt), up, CNT_W));
    end
  end

endmodule

// File: rtl/branch_predictor_table.sv
// PC-indexed branch direction predictor. A table of saturating counters is
// looked up combinationally from the fetch PC (optionally hashed with the
// global history) and trained by the execute stage when a branch resolves.
// History and statistics are only updated at resolution, never speculatively.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int IDX_W    = 6,
  parameter int CNT_W    = 2,
  parameter int GHR_W    = 6,
  parameter int MODE     = BP_MODE_BIMODAL,
  parameter int CNT_INIT = BP_CNT_INIT_DEFAULT,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_pred,
  output logic [GHR_W-1:0]  ghr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [CNT_W-1:0] cnt [ENTRIES];
  logic [IDX_W-1:0] pc_idx;
  logic [GHR_W-1:0] ghr_next;
  logic             mispred;

  // Instructions are word aligned, so the two low PC bits carry no
  // information; bits above the index only alias into the same entry.
  logic pc_unused;
  assign pc_unused = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

  assign pc_idx = lookup_pc[IDX_W+1:2];

  // Index selection: the history is zero-extended to the index width so a
  // short GHR only perturbs the low index bits.
  generate
    if (MODE == BP_MODE_GSHARE) begin : g_gshare
      assign pred_idx = pc_idx ^ IDX_W'(ghr);
    end else begin : g_bimodal
      assign pred_idx = pc_idx;
    end
  endgenerate

  // Direction is the counter MSB; lookup sees the pre-update table, so a
  // same-cycle update to the same entry becomes visible one cycle later.
  assign pred_taken = cnt[pred_idx][CNT_W-1];

  // One counter per table entry, trained only when its index resolves
  generate
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
      logic hit;
      assign hit = upd_valid && (upd_idx == IDX_W'(i));

      bp_sat_counter #(
        .CNT_W    (CNT_W),
        .CNT_INIT (CNT_INIT)
      ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (hit),
        .up    (upd_taken),
        .cnt   (cnt[i])
      );
    end
  endgenerate

  // Shift the resolved outcome into the history; a 1-bit history simply
  // holds the most recent outcome.
  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign ghr_next = upd_taken;
    end else begin : g_ghr_shift
      assign ghr_next = {ghr[GHR_W-2:0], upd_taken};
    end
  endgenerate

  assign mispred = (upd_pred != upd_taken);

  // Global history register, advanced only by resolved branches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (clear) begin
      ghr <= '0;
    end else if (upd_valid) begin
      ghr <= ghr_next;
    end
  end

  // Resolved-branch and misprediction counts; both stick at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (clear) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (upd_valid) begin
      stat_branches <= STAT_W'(sat_step(BP_SAT_MAX_W'(stat_branches), 1'b1, STAT_W));
      if (mispred) begin
        stat_mispred <= STAT_W'(sat_step(BP_SAT_MAX_W'(stat_mispred), 1'b1, STAT_W));
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed bench for branch_predictor_table: a bimodal instance with 4-bit
// statistics driven from a vector table plus hand sequences, and a gshare
// instance exercising history-based indexing and same-cycle collisions.
module tb_branch_predictor_table;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  // Bimodal instance, STAT_W = 4
  logic        b_clear, b_uv, b_ut, b_up, b_pt;
  logic [31:0] b_pc;
  logic [5:0]  b_ui, b_pidx, b_ghr;
  logic [3:0]  b_sb, b_sm;

  branch_predictor_table #(
    .PC_W(32), .IDX_W(6), .CNT_W(2), .GHR_W(6), .MODE(0), .CNT_INIT(1), .STAT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .clear(b_clear), .lookup_pc(b_pc),
    .pred_taken(b_pt), .pred_idx(b_pidx), .upd_valid(b_uv), .upd_idx(b_ui),
    .upd_taken(b_ut), .upd_pred(b_up), .ghr(b_ghr),
    .stat_branches(b_sb), .stat_mispred(b_sm)
  );

  // Gshare instance, default statistics width
  logic        g_clear, g_uv, g_ut, g_up, g_pt;
  logic [31:0] g_pc;
  logic [5:0]  g_ui, g_pidx, g_ghr;
  logic [31:0] g_sb, g_sm;

  branch_predictor_table #(
    .PC_W(32), .IDX_W(6), .CNT_W(2), .GHR_W(6), .MODE(1), .CNT_INIT(1), .STAT_W(32)
  ) dut_g (
    .clk(clk), .rst(rst), .clear(g_clear), .lookup_pc(g_pc),
    .pred_taken(g_pt), .pred_idx(g_pidx), .upd_valid(g_uv), .upd_idx(g_ui),
    .upd_taken(g_ut), .upd_pred(g_up), .ghr(g_ghr),
    .stat_branches(g_sb), .stat_mispred(g_sm)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Vector: update inputs and lookup PC applied together; expectations are
  // the outputs seen before the following rising edge (pre-update state).
  typedef struct {
    logic        uv;
    logic [5:0]  ui;
    logic        ut;
    logic        up;
    logic [31:0] pc;
    logic [5:0]  e_idx;
    logic        e_pt;
    logic [3:0]  e_sb;
    logic [3:0]  e_sm;
    logic [5:0]  e_ghr;
  } vec_t;

  vec_t vecs[12];

  task automatic b_upd(input logic [5:0] idx, input logic taken, input logic pred);
    @(negedge clk);
    b_uv = 1'b1; b_ui = idx; b_ut = taken; b_up = pred;
    @(posedge clk);
    #1 b_uv = 1'b0;
  endtask

  task automatic g_upd(input logic [5:0] idx, input logic taken, input logic pred);
    @(negedge clk);
    g_uv = 1'b1; g_ui = idx; g_ut = taken; g_up = pred;
    @(posedge clk);
    #1 g_uv = 1'b0;
  endtask

  initial begin
    //            uv  ui  ut  up  pc            idx pt  sb  sm  ghr
    vecs[0]  = '{1'b0, 6'd0,  1'b0, 1'b0, 32'h0000_0040, 6'd16, 1'b0, 4'd0, 4'd0, 6'd0};
    vecs[1]  = '{1'b1, 6'd16, 1'b1, 1'b0, 32'h0000_0040, 6'd16, 1'b0, 4'd0, 4'd0, 6'd0};
    vecs[2]  = '{1'b1, 6'd16, 1'b1, 1'b1, 32'h0000_0040, 6'd16, 1'b1, 4'd1, 4'd1, 6'd1};
    vecs[3]  = '{1'b1, 6'd16, 1'b1, 1'b1, 32'h0000_0040, 6'd16, 1'b1, 4'd2, 4'd1, 6'd3};
    vecs[4]  = '{1'b1, 6'd16, 1'b0, 1'b1, 32'h0000_0040, 6'd16, 1'b1, 4'd3, 4'd1, 6'd7};
    vecs[5]  = '{1'b0, 6'd0,  1'b0, 1'b0, 32'h0000_0040, 6'd16, 1'b1, 4'd4, 4'd2, 6'd14};
    vecs[6]  = '{1'b1, 6'd5,  1'b0, 1'b1, 32'h0000_0014, 6'd5,  1'b0, 4'd4, 4'd2, 6'd14};
    vecs[7]  = '{1'b1, 6'd5,  1'b0, 1'b1, 32'h0000_0014, 6'd5,  1'b0, 4'd5, 4'd3, 6'd28};
    vecs[8]  = '{1'b1, 6'd5,  1'b0, 1'b1, 32'h0000_0014, 6'd5,  1'b0, 4'd6, 4'd4, 6'd56};
    vecs[9]  = '{1'b1, 6'd5,  1'b0, 1'b1, 32'h0000_0014, 6'd5,  1'b0, 4'd7, 4'd5, 6'd48};
    vecs[10] = '{1'b0, 6'd0,  1'b0, 1'b0, 32'h0000_0014, 6'd5,  1'b0, 4'd8, 4'd6, 6'd32};
    vecs[11] = '{1'b0, 6'd0,  1'b0, 1'b0, 32'hFFFF_FF43, 6'd16, 1'b1, 4'd8, 4'd6, 6'd32};

    b_clear = 0; b_uv = 0; b_ui = 0; b_ut = 0; b_up = 0; b_pc = 32'h40;
    g_clear = 0; g_uv = 0; g_ui = 0; g_ut = 0; g_up = 0; g_pc = 32'h40;

    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Gshare: reset defaults
    #1;
    check("g_reset_idx", g_pidx, 16);
    check("g_reset_pt", g_pt, 0);
    check("g_reset_ghr", g_ghr, 0);
    check("g_reset_sb", g_sb, 0);
    check("g_reset_sm", g_sm, 0);

    // Gshare: history T,T,N then hashed lookup
    g_upd(6'd0, 1'b1, 1'b0);
    g_upd(6'd0, 1'b1, 1'b0);
    g_upd(6'd0, 1'b0, 1'b0);
    #1;
    check("g_ghr_ttn", g_ghr, 6'b000110);
    check("g_hash_idx", g_pidx, 22);
    check("g_hash_pt", g_pt, 0);

    // Gshare: same-cycle update and lookup of entry 22
    @(negedge clk);
    g_pc = 32'h40; g_uv = 1'b1; g_ui = 6'd22; g_ut = 1'b1; g_up = 1'b0;
    #1;
    check("g_coll_idx_same", g_pidx, 22);
    check("g_coll_pt_same", g_pt, 0);
    @(posedge clk);
    #1 g_uv = 1'b0;
    g_pc = 32'h0000_006C;  // 27 ^ ghr(13) = 22
    #1;
    check("g_coll_ghr", g_ghr, 13);
    check("g_coll_idx_next", g_pidx, 22);
    check("g_coll_pt_next", g_pt, 1);
    check("g_sb", g_sb, 4);
    check("g_sm", g_sm, 3);

    // Bimodal: table-driven vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      b_uv = vecs[i].uv; b_ui = vecs[i].ui; b_ut = vecs[i].ut;
      b_up = vecs[i].up; b_pc = vecs[i].pc;
      #1;
      check($sformatf("v%0d_idx", i), b_pidx, vecs[i].e_idx);
      check($sformatf("v%0d_pt", i), b_pt, vecs[i].e_pt);
      check($sformatf("v%0d_sb", i), b_sb, vecs[i].e_sb);
      check($sformatf("v%0d_sm", i), b_sm, vecs[i].e_sm);
      check($sformatf("v%0d_ghr", i), b_ghr, vecs[i].e_ghr);
    end

    // Bimodal: clear wins over a simultaneous taken update to entry 16
    @(negedge clk);
    b_uv = 1'b0; b_pc = 32'h40;
    b_clear = 1'b1; b_uv = 1'b1; b_ui = 6'd16; b_ut = 1'b1; b_up = 1'b0;
    @(posedge clk);
    #1 b_clear = 1'b0; b_uv = 1'b0;
    #1;
    check("clr_ghr", b_ghr, 0);
    check("clr_sb", b_sb, 0);
    check("clr_sm", b_sm, 0);
    check("clr_pt16", b_pt, 0);

    // Entry 5 was at 0; after clear it is 1, so one taken update flips it
    b_upd(6'd5, 1'b1, 1'b1);
    b_pc = 32'h14;
    #1;
    check("clr_pt5", b_pt, 1);
    check("clr_sb1", b_sb, 1);
    check("clr_sm0", b_sm, 0);

    // Statistics saturation: 17 more resolved mispredicted branches
    for (int k = 0; k < 17; k++) b_upd(6'd5, 1'b1, 1'b0);
    #1;
    check("sat_sb", b_sb, 15);
    check("sat_sm", b_sm, 15);
    check("sat_ghr", b_ghr, 63);
    check("sat_pt5", b_pt, 1);

    // Asynchronous reset between edges
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_ghr", b_ghr, 0);
    check("arst_sb", b_sb, 0);
    check("arst_sm", b_sm, 0);
    check("arst_pt5", b_pt, 0);
    check("arst_g_ghr", g_ghr, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_rel_pt5", b_pt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
- Parametrised PC-indexed branch direction predictor: a table of ENTRIES saturating counters, each CNT_W bits wide.
- Two indexing modes: bimodal (PC only) or gshare (PC XOR global history register).
- Lookup is combinational from the IF-stage PC. The update port is driven by the EX stage on branch resolution.
- Saturating statistics counters track the number of resolved branches and mispredictions.

Parameters:
- PC_W, 32, PC width.
- IDX_W, 6, table index width; ENTRIES = 2**IDX_W.
- CNT_W, 2, counter width; must be >= 1.
- GHR_W, 6, global history length; must satisfy 1 <= GHR_W <= IDX_W.
- MODE, 0, selects indexing: 0 = bimodal, 1 = gshare.
- CNT_INIT, 1, counter value after reset and after clear. Default 1 is weakly not-taken for CNT_W = 2.
- STAT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of the table, GHR and statistics.
- lookup_pc  in  PC_W  PC of the instruction in IF.
- pred_taken  out  1  predicted direction for lookup_pc.
- pred_idx  out  IDX_W  table index used; carried down the pipeline to the update port.
- upd_valid  in  1  a branch resolved this cycle.
- upd_idx  in  IDX_W  pred_idx captured at lookup time.
- upd_taken  in  1  actual branch outcome.
- upd_pred  in  1  prediction that was made for this branch.
- ghr  out  GHR_W  current global history.
- stat_branches  out  STAT_W  number of resolved branches.
- stat_mispred  out  STAT_W  number of mispredicted branches.

Behaviour:
- Reset (rst = 0, asynchronous):
  - every counter = CNT_INIT;
  - ghr = 0;
  - stat_branches = 0, stat_mispred = 0.
  - pred_taken and pred_idx follow combinationally from the reset state.
- Index computation:
  - pc_idx = lookup_pc[IDX_W+1:2].
  - MODE 0: pred_idx = pc_idx.
  - MODE 1: pred_idx = pc_idx XOR zero-extended ghr.
- Prediction: pred_taken = MSB of counter[pred_idx]. Zero latency, purely combinational.
- Update (rising clk with upd_valid = 1):
  - upd_taken = 1: counter[upd_idx] increments, saturating at 2**CNT_W - 1.
  - upd_taken = 0: counter[upd_idx] decrements, saturating at 0.
  - ghr <= {ghr[GHR_W-2:0], upd_taken}. When GHR_W = 1, ghr <= upd_taken.
  - stat_branches increments.
  - stat_mispred increments when upd_pred != upd_taken.
  - Both statistics counters saturate at all-ones and never wrap.
  - upd_valid = 0: no state changes.
- History is non-speculative: ghr is updated only at resolution. A lookup issued in the same cycle as an update uses the pre-update ghr.
- Lookup and update to the same index in the same cycle: no bypass. pred_taken reflects the old counter value; the new value is visible from the next cycle.
- clear = 1 at a rising clk:
  - same state as reset; takes priority over a simultaneous upd_valid, so the update is dropped.
  - resumes normal operation on the next cycle.
- rst asserted mid-operation: all state is immediately forced to reset values; any in-flight update is lost.
- upd_idx is used as supplied; the block never recomputes it from a PC.

Decomposition:
- Shared package bp_pkg holds:
  - mode constants BP_MODE_BIMODAL = 0 and BP_MODE_GSHARE = 1;
  - a saturating increment/decrement function, parameterised on width and also reused by the stat counters;
  - the default CNT_INIT constant.
- One natural sub-module: bp_sat_counter, a single CNT_W-bit saturating counter with update enable and direction input. It is instantiated ENTRIES times in a generate loop. Counters are flops, not memory macros, because reset must be asynchronous.

Test Plan:
- Reset defaults, MODE 0, CNT_W 2:
  - after rst release, lookup_pc = 0x0000_0040 -> pred_idx = 16, pred_taken = 0;
  - ghr = 0; both statistics counters = 0.
- Saturation up, idx 16:
  - 3 updates with upd_taken = 1 -> counter 1→2→3→3; pred_taken = 1 from the cycle after the first update.
  - then 1 not-taken update -> counter 2, pred_taken still 1.
- Saturation down, idx 5:
  - 4 updates with upd_taken = 0 -> counter 0, pred_taken = 0.
  - upd_pred = 1 on all four -> stat_mispred = 4, stat_branches = 4.
- gshare indexing, MODE 1, IDX_W 6, GHR_W 6:
  - resolve taken, taken, not-taken -> ghr = 6'b000110;
  - then lookup_pc = 0x0000_0040 -> pred_idx = 16 XOR 6 = 22.
- Same-cycle collision at idx 22, counter 1:
  - update taken while looking up idx 22 -> pred_taken = 0 in that cycle, 1 in the next.
- Clear and reset priority:
  - clear = 1 together with upd_valid = 1 -> all counters 1, ghr 0, stats 0, update not applied.
  - rst pulsed low between clock edges -> outputs return to reset values before the next rising edge.
  - with STAT_W = 4, 17 resolved branches -> stat_branches holds at 15.
